// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: register-to-register bus transfer sequencer.
// Accepts a source/destination code pair and runs a fixed
// DRIVE -> LATCH -> DONE sequence of one-hot bus strobes.
// Optional build macro: BUS_XFER_BACK2BACK_EN lets a new start be accepted in
// DONE, giving one transfer per 3 cycles instead of 4.
// All outputs are registered and show the state held before the edge, so
// each strobe appears one cycle after the FSM enters the matching state.
module bus_xfer_seq (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [4:0]  src_sel,
    input  logic [4:0]  dst_sel,
    output logic [23:0] out_en,
    output logic [23:0] in_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] MAX_CODE = 5'd23;

    state_t     state;
    logic [4:0] src_q;
    logic [4:0] dst_q;
    logic       codes_ok;

    // Codes above 23 name no register; captured codes are always in range.
    function automatic logic [23:0] hot(input logic [4:0] code);
        return 24'(1) << code;
    endfunction

    assign codes_ok = (src_sel <= MAX_CODE) && (dst_sel <= MAX_CODE);

    // Sequencer state, captured codes and registered strobes/flags.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            out_en     <= '0;
            in_en      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            out_en <= '0;
            in_en  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (codes_ok) begin
                            src_q <= src_sel;
                            dst_q <= dst_sel;
                            state <= DRIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    // Bus-settle cycle: source drives, nothing loads yet.
                    out_en <= hot(src_q);
                    state  <= LATCH;
                end
                LATCH: begin
                    out_en <= hot(src_q);
                    in_en  <= hot(dst_q);
                    state  <= DONE;
                end
                DONE: begin
                    done       <= 1'b1;
                    xfer_count <= xfer_count + 16'd1;
                    state      <= IDLE;
`ifdef BUS_XFER_BACK2BACK_EN
                    if (start) begin
                        if (codes_ok) begin
                            src_q <= src_sel;
                            dst_q <= dst_sel;
                            state <= DRIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Testbench for bus_xfer_seq: directed scenarios plus random traffic,
// checked against a timeline model that schedules expected strobes per edge.
module tb_bus_xfer_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [4:0]  src_sel;
    logic [4:0]  dst_sel;
    logic [23:0] out_en;
    logic [23:0] in_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

`ifdef BUS_XFER_BACK2BACK_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 4;
`endif
    localparam int DEPTH = 4096;

    // Timeline model: expected values indexed by posedge number since reset.
    logic [23:0] exp_out [DEPTH];
    logic [23:0] exp_in  [DEPTH];
    bit          exp_busy[DEPTH];
    bit          exp_done[DEPTH];
    bit          exp_err [DEPTH];
    bit          cnt_inc [DEPTH];
    logic [15:0] model_count;
    int          next_free;
    int          k;

    bus_xfer_seq dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .out_en    (out_en),
        .in_en     (in_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            exp_out[i] = '0; exp_in[i] = '0; exp_busy[i] = 0;
            exp_done[i] = 0; exp_err[i] = 0; cnt_inc[i] = 0;
        end
        model_count = '0;
        next_free   = 0;
        k           = -1;
    endtask

    // One clock: apply inputs, let the edge happen, predict, then check.
    task automatic step(input bit st, input logic [4:0] s, input logic [4:0] d);
        start = st; src_sel = s; dst_sel = d;
        @(posedge clock);
        k++;
        if (cnt_inc[k]) model_count = model_count + 16'd1;
        if (st && k >= next_free) begin
            if (s < 24 && d < 24) begin
                exp_out[k+1] = 24'(1) << s;
                exp_out[k+2] = 24'(1) << s;
                exp_in[k+2]  = 24'(1) << d;
                exp_done[k+3] = 1;
                cnt_inc[k+3]  = 1;
                for (int j = 1; j <= 3; j++) exp_busy[k+j] = 1;
                next_free = k + GAP;
            end else begin
                exp_err[k] = 1;
            end
        end
        @(negedge clock);
        chk("out_en", 32'(out_en), 32'(exp_out[k]));
        chk("in_en",  32'(in_en),  32'(exp_in[k]));
        chk("busy",   32'(busy),   32'(exp_busy[k]));
        chk("done",   32'(done),   32'(exp_done[k]));
        chk("err",    32'(err),    32'(exp_err[k]));
        chk("count",  32'(xfer_count), 32'(model_count));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0);
    endtask

    // Strobes are never allowed to carry more than one bit.
    always @(negedge clock) begin
        checks++;
        assert ($onehot0(out_en) && $onehot0(in_en)) else begin
            errors++;
            $error("FAIL onehot observed out_en %0h in_en %0h expected zero or one-hot", out_en, in_en);
        end
    end

    initial begin
        logic [15:0] c0;
        start = 0; src_sel = 0; dst_sel = 0;
        clear_n = 1'b0;
        model_reset();
        #2;
        chk("rst_out", 32'(out_en), 32'h0);
        chk("rst_in",  32'(in_en),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(xfer_count), 32'h0);
        @(negedge clock); @(negedge clock);
        clear_n = 1'b1;

        // Basic PC -> MAR transfer, accepted on the first edge after reset.
        step(1'b1, 5'd21, 5'd22);
        step(1'b0, 5'd0, 5'd0);
        chk("basic_out", 32'(out_en), 32'h200000);
        step(1'b0, 5'd0, 5'd0);
        chk("basic_in", 32'(in_en), 32'h400000);
        step(1'b0, 5'd0, 5'd0);
        chk("basic_cnt", 32'(xfer_count), 32'h1);
        idle(2);

        // Invalid source code.
        step(1'b1, 5'd25, 5'd3);
        chk("inv_err", 32'(err), 32'h1);
        idle(3);

        // Start held high for 6 cycles.
        c0 = xfer_count;
        for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 5'd8);
        idle(5);
        chk("hold_cnt", 32'(xfer_count), 32'(c0 + 16'd2));

        // Same source and destination.
        step(1'b1, 5'd7, 5'd7);
        idle(5);

        // Reset during LATCH of MDR -> IR.
        step(1'b1, 5'd16, 5'd23);
        step(1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 5'd0);
        #2 clear_n = 1'b0;
        #1;
        chk("abort_in",  32'(in_en),  32'h0);
        chk("abort_out", 32'(out_en), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_cnt", 32'(xfer_count), 32'h0);
        @(negedge clock);
        chk("abort_done", 32'(done), 32'h0);
        clear_n = 1'b1;
        model_reset();

        // Counter wrap from 0xFFFF.
        idle(1);
        force dut.xfer_count = 16'hFFFF;
        #1 release dut.xfer_count;
        model_count = 16'hFFFF;
        step(1'b1, 5'd1, 5'd2);
        idle(5);
        chk("wrap", 32'(xfer_count), 32'h0);

        // Random traffic, some invalid codes, start toggling.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 27)), 5'($urandom_range(0, 27)));
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
